// File: rtl/pacman_pkg.sv
// Shared types, colours and the fixed 16x16 wall map for the Pac-Man playfield.
package pacman_pkg;

  typedef enum logic [3:0] {
    DIR_NONE = 4'b0000,
    DIR_R    = 4'b0001,
    DIR_L    = 4'b0010,
    DIR_U    = 4'b0100,
    DIR_D    = 4'b1000
  } dir_t;

  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] WALL   = 12'h00F;
  localparam logic [11:0] BLACK  = 12'h000;

  localparam int TILE = 30;

  // Row-major; bit c of row r is tile (col c, row r). Border is solid, row 1 and col 1 are open.
  localparam logic [15:0] MAZE_WALLS [16] = '{
    16'hFFFF, 16'h8001, 16'hB6D9, 16'h8241, 16'hBA5D, 16'h8811, 16'hABD5, 16'h8201,
    16'hBEFD, 16'h8081, 16'hADB5, 16'h8421, 16'hB5AD, 16'h8101, 16'h8001, 16'hFFFF
  };

  function automatic logic wall_at(input int col, input int row);
    if (col < 0 || col > 15 || row < 0 || row > 15) return 1'b1;
    return MAZE_WALLS[row][col];
  endfunction

  function automatic logic blocked(input dir_t d, input logic [3:0] tx, input logic [3:0] ty);
    int c, r;
    c = int'(tx);
    r = int'(ty);
    case (d)
      DIR_R:   return wall_at(c + 1, r);
      DIR_L:   return wall_at(c - 1, r);
      DIR_U:   return wall_at(c, r - 1);
      DIR_D:   return wall_at(c, r + 1);
      default: return 1'b1;
    endcase
  endfunction

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_R:   return DIR_L;
      DIR_L:   return DIR_R;
      DIR_U:   return DIR_D;
      DIR_D:   return DIR_U;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pacman_sprite.sv
// Combinational Pac-Man disk fill test; mouth wedge removed when PACMAN_MOUTH_EN is defined.
module pacman_sprite
  import pacman_pkg::*;
(
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [9:0] pm_xpos,
  input  logic [9:0] pm_ypos,
  input  logic [3:0] direction,
  output logic       hit
);

  logic signed [10:0] dx, dy;
  logic signed [23:0] dx_e, dy_e, dist2;
  logic               disk;

  always_comb begin
    dx    = $signed({1'b0, h_count}) - $signed({1'b0, pm_xpos}) - 11'sd15;
    dy    = $signed({1'b0, v_count}) - $signed({1'b0, pm_ypos}) - 11'sd15;
    dx_e  = 24'(dx);
    dy_e  = 24'(dy);
    dist2 = dx_e * dx_e + dy_e * dy_e;
    disk  = (dist2 <= 24'sd196);
  end

`ifdef PACMAN_MOUTH_EN
  logic signed [10:0] adx, ady;
  logic               mouth;

  always_comb begin
    adx   = (dx < 0) ? -dx : dx;
    ady   = (dy < 0) ? -dy : dy;
    mouth = 1'b0;
    case (direction)
      DIR_R:   mouth = (dx > 0) && (ady < dx);
      DIR_L:   mouth = (dx < 0) && (ady < -dx);
      DIR_U:   mouth = (dy < 0) && (adx < -dy);
      DIR_D:   mouth = (dy > 0) && (adx < dy);
      default: mouth = 1'b0;
    endcase
    hit = disk && !mouth;
  end
`else
  logic unused_dir;
  assign unused_dir = ^direction;
  assign hit        = disk;
`endif

endmodule

// File: rtl/pacman_scene.sv
// Pac-Man tile movement and per-pixel playfield rendering. Optional mouth: PACMAN_MOUTH_EN.
module pacman_scene
  import pacman_pkg::*;
#(
  parameter int H_START = 150,
  parameter int V_START = 34,
  parameter int TILE    = pacman_pkg::TILE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_tick,
  input  logic        bright,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [9:0]  pm_xpos,
  output logic [9:0]  pm_ypos,
  output logic [3:0]  pm_direction
);

  localparam logic [4:0] OFF_MAX = 5'(TILE - 1);

  dir_t       dir, dir_n, pending, pending_n, req;
  logic [3:0] tx, ty, tx_n, ty_n;
  logic [4:0] ox, oy, ox_n, oy_n;
  logic       aligned, consumed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir     <= DIR_NONE;
      pending <= DIR_NONE;
      tx      <= 4'd1;
      ty      <= 4'd1;
      ox      <= '0;
      oy      <= '0;
    end else begin
      dir     <= dir_n;
      pending <= pending_n;
      tx      <= tx_n;
      ty      <= ty_n;
      ox      <= ox_n;
      oy      <= oy_n;
    end
  end

  always_comb begin
    req = up ? DIR_U : down ? DIR_D : left ? DIR_L : right ? DIR_R : DIR_NONE;
  end

  always_comb begin
    dir_n    = dir;
    tx_n     = tx;
    ty_n     = ty;
    ox_n     = ox;
    oy_n     = oy;
    consumed = 1'b0;
    aligned  = (ox == '0) && (oy == '0);
    if (move_tick) begin
      if (aligned && pending != DIR_NONE && !blocked(pending, tx, ty)) begin
        dir_n    = pending;
        consumed = 1'b1;
      end else if (dir != DIR_NONE && pending == opposite(dir)) begin
        dir_n    = pending;
        consumed = 1'b1;
      end
      // Only an aligned sprite can face a wall; mid-tile it always finishes the step.
      if (!(aligned && blocked(dir_n, tx, ty))) begin
        case (dir_n)
          DIR_R: if (ox == OFF_MAX) begin ox_n = '0; tx_n = tx + 4'd1; end else ox_n = ox + 5'd1;
          DIR_D: if (oy == OFF_MAX) begin oy_n = '0; ty_n = ty + 4'd1; end else oy_n = oy + 5'd1;
          DIR_L: if (aligned) begin ox_n = OFF_MAX; tx_n = tx - 4'd1; end else ox_n = ox - 5'd1;
          DIR_U: if (aligned) begin oy_n = OFF_MAX; ty_n = ty - 4'd1; end else oy_n = oy - 5'd1;
          default: ;
        endcase
      end
    end
    pending_n = (req != DIR_NONE) ? req : (consumed ? DIR_NONE : pending);
  end

  assign pm_xpos      = 10'(H_START + TILE * int'(tx) + int'(ox));
  assign pm_ypos      = 10'(V_START + TILE * int'(ty) + int'(oy));
  assign pm_direction = dir;

  logic sprite_hit;

  pacman_sprite u_sprite (
    .h_count   (hCount),
    .v_count   (vCount),
    .pm_xpos   (pm_xpos),
    .pm_ypos   (pm_ypos),
    .direction (pm_direction),
    .hit       (sprite_hit)
  );

  int   px, py;
  logic in_field;

  always_comb begin
    px       = int'(hCount) - H_START;
    py       = int'(vCount) - V_START;
    in_field = (px >= 0) && (px < 16 * TILE) && (py >= 0) && (py < 16 * TILE);
    rgb      = BLACK;
    if (!bright)         rgb = BLACK;
    else if (sprite_hit) rgb = YELLOW;
    else if (in_field)   rgb = wall_at(px / TILE, py / TILE) ? WALL : BLACK;
  end

endmodule

// File: tb/tb_pacman_scene.sv
// Directed self-checking bench for pacman_scene: reset, movement, blocking, reversal, rendering.
module tb_pacman_scene;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_tick = 1'b0;
  logic        bright = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [9:0]  hCount = '0, vCount = '0;
  logic [11:0] rgb;
  logic [9:0]  pm_xpos, pm_ypos;
  logic [3:0]  pm_direction;

  int total = 0;
  int bad   = 0;

  pacman_scene #(.H_START(150), .V_START(34), .TILE(30)) dut (
    .clk          (clk),
    .rst          (rst),
    .move_tick    (move_tick),
    .bright       (bright),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .hCount       (hCount),
    .vCount       (vCount),
    .rgb          (rgb),
    .pm_xpos      (pm_xpos),
    .pm_ypos      (pm_ypos),
    .pm_direction (pm_direction)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    {up, down, left, right} = 4'b0000;
    move_tick = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) move_tick = 1'b1;
      @(negedge clk) move_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pm_xpos !== 10'd180) begin bad++; $display("FAIL reset_x got=%0d exp=180", pm_xpos); end
    total++; if (pm_ypos !== 10'd64) begin bad++; $display("FAIL reset_y got=%0d exp=64", pm_ypos); end
    total++; if (pm_direction !== 4'b0000) begin bad++; $display("FAIL reset_dir got=%b exp=0000", pm_direction); end
  endtask

  task automatic test_render();
    logic [9:0]  hv [6][2];
    logic [11:0] ev [6];
    hv = '{'{10'd195, 10'd79}, '{10'd209, 10'd79}, '{10'd210, 10'd79},
           '{10'd150, 10'd34}, '{10'd240, 10'd64}, '{10'd100, 10'd100}};
    ev = '{12'hFF0, 12'hFF0, 12'h000, 12'h00F, 12'h000, 12'h000};
    bright = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hCount = hv[i][0]; vCount = hv[i][1]; #1;
      total++;
      if (rgb !== ev[i]) begin bad++; $display("FAIL pixel_%0d_%0d got=%h exp=%h", hCount, vCount, rgb, ev[i]); end
    end
    hCount = 10'd195; vCount = 10'd79; bright = 1'b0; #1;
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL blank_pixel got=%h exp=000", rgb); end
    bright = 1'b1;
  endtask

  task automatic test_blocked_up();
    do_reset();
    up = 1'b1; @(negedge clk);
    ticks(10);
    up = 1'b0;
    total++; if (pm_ypos !== 10'd64 || pm_xpos !== 10'd180) begin bad++; $display("FAIL blocked_up got=%0d,%0d exp=180,64", pm_xpos, pm_ypos); end
    total++; if (pm_direction !== 4'b0000) begin bad++; $display("FAIL blocked_up_dir got=%b exp=0000", pm_direction); end
  endtask

  task automatic test_priority();
    do_reset();
    up = 1'b1; right = 1'b1; @(negedge clk);
    ticks(1);
    {up, right} = 2'b00;
    total++; if (pm_direction !== 4'b0000 || pm_xpos !== 10'd180) begin bad++; $display("FAIL priority got=%b,%0d exp=0000,180", pm_direction, pm_xpos); end
  endtask

  task automatic test_move_right();
    do_reset();
    right = 1'b1; @(negedge clk);
    ticks(1);
    total++; if (pm_xpos !== 10'd181) begin bad++; $display("FAIL right_1 got=%0d exp=181", pm_xpos); end
    ticks(29);
    right = 1'b0;
    total++; if (pm_xpos !== 10'd210 || pm_ypos !== 10'd64) begin bad++; $display("FAIL right_30 got=%0d,%0d exp=210,64", pm_xpos, pm_ypos); end
    total++; if (pm_direction !== 4'b0001) begin bad++; $display("FAIL right_dir got=%b exp=0001", pm_direction); end
    hCount = 10'd230; vCount = 10'd79; bright = 1'b1; #1;
`ifdef PACMAN_MOUTH_EN
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL mouth_pixel got=%h exp=000", rgb); end
`else
    total++; if (rgb !== 12'hFF0) begin bad++; $display("FAIL mouth_pixel got=%h exp=FF0", rgb); end
`endif
  endtask

  task automatic test_reverse();
    do_reset();
    right = 1'b1; @(negedge clk);
    ticks(12);
    right = 1'b0;
    total++; if (pm_xpos !== 10'd192) begin bad++; $display("FAIL rev_pre got=%0d exp=192", pm_xpos); end
    left = 1'b1; @(negedge clk);
    ticks(1);
    left = 1'b0;
    total++; if (pm_xpos !== 10'd191 || pm_direction !== 4'b0010) begin bad++; $display("FAIL reverse got=%0d,%b exp=191,0010", pm_xpos, pm_direction); end
    ticks(11);
    total++; if (pm_xpos !== 10'd180) begin bad++; $display("FAIL rev_back got=%0d exp=180", pm_xpos); end
    ticks(2);
    total++; if (pm_xpos !== 10'd180 || pm_direction !== 4'b0010) begin bad++; $display("FAIL left_wall got=%0d,%b exp=180,0010", pm_xpos, pm_direction); end
  endtask

  task automatic test_down_up();
    do_reset();
    down = 1'b1; @(negedge clk);
    ticks(30);
    down = 1'b0;
    total++; if (pm_ypos !== 10'd94 || pm_direction !== 4'b1000) begin bad++; $display("FAIL down_30 got=%0d,%b exp=94,1000", pm_ypos, pm_direction); end
    up = 1'b1; @(negedge clk);
    ticks(1);
    up = 1'b0;
    total++; if (pm_ypos !== 10'd93 || pm_direction !== 4'b0100) begin bad++; $display("FAIL up_wrap got=%0d,%b exp=93,0100", pm_ypos, pm_direction); end
  endtask

  task automatic test_async_reset();
    do_reset();
    right = 1'b1; @(negedge clk);
    ticks(5);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    total++; if (pm_xpos !== 10'd180 || pm_direction !== 4'b0000) begin bad++; $display("FAIL async_rst got=%0d,%b exp=180,0000", pm_xpos, pm_direction); end
    right = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_render();
    test_blocked_up();
    test_priority();
    test_move_right();
    test_reverse();
    test_down_up();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
